// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: qualifies retiring instructions from writeback and queues them in a
// small FIFO. It drains the FIFO to the difftest side with valid/ready, and reports the
// simulation trap only after every earlier commit has been consumed.
module commit_trace_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [63:0] PC_START    = 64'h0000_0000_8000_0000,
  parameter logic [6:0]  TRAP_OPCODE = 7'h6b
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              wb_pc,
  input  logic [31:0]              wb_inst,
  input  logic [7:0]               wb_rf_we,
  input  logic [4:0]               wb_rf_wnum,
  input  logic [63:0]              wb_rf_wdata,
  input  logic [63:0]              a0_value,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_rfwen,
  output logic [7:0]               out_wdest,
  output logic [63:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     trap,
  output logic [7:0]               trap_code,
  output logic [63:0]              trap_pc,
  output logic [63:0]              cycle_cnt,
  output logic [63:0]              instr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e state_q, state_d;

  logic [63:0] mem_pc    [DEPTH];
  logic [31:0] mem_inst  [DEPTH];
  logic        mem_rfwen [DEPTH];
  logic [4:0]  mem_wnum  [DEPTH];
  logic [63:0] mem_wdata [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [7:0]    trap_code_q;
  logic [63:0]   trap_pc_q;
  logic [63:0]   cycle_q;
  logic [63:0]   instr_q;

  logic accepting, halted, head_valid;
  logic in_valid, full, do_pop, do_push, drop, trap_hit;

  // Only the low byte of a0 is reported as the trap code
  logic unused_a0;
  assign unused_a0 = ^a0_value[63:8];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StRun;
    else       state_q <= state_d;
  end

  // Next state: a trap moves to DRAIN; DRAIN halts once the FIFO is (or becomes) empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (trap_hit) state_d = StDrain;
      StDrain: if ((count_q == '0) || ((count_q == CW'(1)) && do_pop)) state_d = StHalted;
      StHalted: state_d = StHalted;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs
  always_comb begin
    accepting  = (state_q == StRun);
    halted     = (state_q == StHalted);
    head_valid = (count_q != '0) && !halted;
  end

  // Qualify the writeback slot and decide push / pop / drop for this cycle
  always_comb begin
    in_valid = ((wb_pc != PC_START) && (wb_pc != '0)) || (wb_inst != '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = head_valid && out_ready;
    // A full FIFO still takes a commit when the head leaves on the same edge
    do_push  = accepting && in_valid && (!full || do_pop);
    drop     = accepting && in_valid && full && !do_pop;
    trap_hit = accepting && in_valid && (wb_inst[6:0] == TRAP_OPCODE);
  end

  // Entry storage; contents need no reset because empty slots are masked on the output
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_pc[wr_ptr_q]    <= wb_pc;
      mem_inst[wr_ptr_q]  <= wb_inst;
      mem_rfwen[wr_ptr_q] <= (|wb_rf_we) && (wb_rf_wnum != '0);
      mem_wnum[wr_ptr_q]  <= wb_rf_wnum;
      mem_wdata[wr_ptr_q] <= wb_rf_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow and one-shot trap capture (only reachable from RUN)
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      trap_code_q <= '0;
      trap_pc_q   <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (trap_hit) begin
        trap_code_q <= a0_value[7:0];
        trap_pc_q   <= wb_pc;
      end
    end
  end

  // Cycle counter runs until halted; instruction counter counts pops
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (!halted) cycle_q <= cycle_q + 64'd1;
      if (do_pop)  instr_q <= instr_q + 64'd1;
    end
  end

  // Head entry, forced to zero when the FIFO is empty
  always_comb begin
    out_pc    = '0;
    out_inst  = '0;
    out_rfwen = 1'b0;
    out_wdest = '0;
    out_wdata = '0;
    if (head_valid) begin
      out_pc    = mem_pc[rd_ptr_q];
      out_inst  = mem_inst[rd_ptr_q];
      out_rfwen = mem_rfwen[rd_ptr_q];
      out_wdest = {3'b000, mem_wnum[rd_ptr_q]};
      out_wdata = mem_wdata[rd_ptr_q];
    end
  end

  assign out_valid = head_valid;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign trap      = halted;
  assign trap_code = trap_code_q;
  assign trap_pc   = trap_pc_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed table, hand-written trap/reset sequences and
// random stimulus, all compared against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] wb_pc;
  logic [31:0] wb_inst;
  logic [7:0]  wb_rf_we;
  logic [4:0]  wb_rf_wnum;
  logic [63:0] wb_rf_wdata;
  logic [63:0] a0_value;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_rfwen;
  logic [7:0]  out_wdest;
  logic [63:0] out_wdata;
  logic [2:0]  count;
  logic        overflow;
  logic        trap;
  logic [7:0]  trap_code;
  logic [63:0] trap_pc;
  logic [63:0] cycle_cnt;
  logic [63:0] instr_cnt;

  always #5 clock = ~clock;

  commit_trace_buffer #(
    .DEPTH      (DEPTH),
    .PC_START   (PC_START),
    .TRAP_OPCODE(7'h6b)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_pc      (wb_pc),
    .wb_inst    (wb_inst),
    .wb_rf_we   (wb_rf_we),
    .wb_rf_wnum (wb_rf_wnum),
    .wb_rf_wdata(wb_rf_wdata),
    .a0_value   (a0_value),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_rfwen  (out_rfwen),
    .out_wdest  (out_wdest),
    .out_wdata  (out_wdata),
    .count      (count),
    .overflow   (overflow),
    .trap       (trap),
    .trap_code  (trap_code),
    .trap_pc    (trap_pc),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rfwen;
    logic [4:0]  wnum;
    logic [63:0] wdata;
  } ent_t;

  ent_t        mq[$];
  logic        m_ovf, m_drain, m_halt;
  logic [7:0]  m_code;
  logic [63:0] m_tpc, m_cyc, m_ins;

  task automatic model_step(input logic rst, input logic [63:0] pc, input logic [31:0] inst,
                            input logic [7:0] we, input logic [4:0] wnum,
                            input logic [63:0] wdata, input logic [63:0] a0, input logic rdy);
    bit   valid_in, pop, was_drain, was_halt;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_drain = 0; m_halt = 0;
      m_code = '0; m_tpc = '0; m_cyc = '0; m_ins = '0;
      return;
    end
    valid_in  = ((pc != PC_START) && (pc != 0)) || (inst != 0);
    pop       = (mq.size() != 0) && rdy;
    was_drain = m_drain;
    was_halt  = m_halt;
    if (!was_drain && !was_halt && valid_in) begin
      if (mq.size() < DEPTH || pop) begin
        e.pc = pc; e.inst = inst; e.rfwen = (we != 0) && (wnum != 0);
        e.wnum = wnum; e.wdata = wdata;
        mq.push_back(e);
      end else begin
        m_ovf = 1;
      end
      if (inst[6:0] == 7'h6b) begin
        m_code  = a0[7:0];
        m_tpc   = pc;
        m_drain = 1;
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      m_ins++;
    end
    if (!was_halt) m_cyc++;
    if (was_drain && mq.size() == 0) begin
      m_drain = 0;
      m_halt  = 1;
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = '{default: '0};
    if (mq.size() != 0) h = mq[0];
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_pc", out_pc, h.pc);
    chk("out_inst", out_inst, h.inst);
    chk("out_rfwen", out_rfwen, h.rfwen);
    chk("out_wdest", out_wdest, {3'b000, h.wnum});
    chk("out_wdata", out_wdata, h.wdata);
    chk("count", count, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("trap", trap, m_halt);
    chk("trap_code", trap_code, m_code);
    chk("trap_pc", trap_pc, m_tpc);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_ins);
  endtask

  // Drive one cycle, advance the model, clock, then compare 1 time unit after the edge
  task automatic step(input logic rst, input logic [63:0] pc, input logic [31:0] inst,
                      input logic [7:0] we, input logic [4:0] wnum, input logic [63:0] wdata,
                      input logic [63:0] a0, input logic rdy);
    reset = rst; wb_pc = pc; wb_inst = inst; wb_rf_we = we; wb_rf_wnum = wnum;
    wb_rf_wdata = wdata; a0_value = a0; out_ready = rdy;
    model_step(rst, pc, inst, we, wnum, wdata, a0, rdy);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] a0,
                        input logic rdy);
    step(1'b0, pc, inst, 8'hFF, 5'd3, pc, a0, rdy);
  endtask

  task automatic bubble(input logic rdy);
    step(1'b0, PC_START, 32'h0, 8'hFF, 5'd3, 64'h0, 64'h0, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 64'h0, 32'h0, 8'h0, 5'd0, 64'h0, 64'h0, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic        rdy;
    logic        ev;
    logic [63:0] epc;
    logic [2:0]  ecnt;
    logic        eovf;
    logic [63:0] eins;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [63:0] rpc;
    logic [31:0] rinst;

    tbl[0]  = '{64'h80000004, 32'h00100093, 5'd1, 64'd1, 1'b1,
                1'b1, 64'h80000004, 3'd1, 1'b0, 64'd0};
    tbl[1]  = '{PC_START, 32'h0, 5'd3, 64'd0, 1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 64'd1};
    tbl[2]  = '{64'h80000100, 32'h13, 5'd3, 64'h100, 1'b0,
                1'b1, 64'h80000100, 3'd1, 1'b0, 64'd1};
    tbl[3]  = '{64'h80000104, 32'h13, 5'd3, 64'h104, 1'b0,
                1'b1, 64'h80000100, 3'd2, 1'b0, 64'd1};
    tbl[4]  = '{64'h80000108, 32'h13, 5'd3, 64'h108, 1'b0,
                1'b1, 64'h80000100, 3'd3, 1'b0, 64'd1};
    tbl[5]  = '{64'h8000010C, 32'h13, 5'd3, 64'h10C, 1'b0,
                1'b1, 64'h80000100, 3'd4, 1'b0, 64'd1};
    // Full with a simultaneous pop: accepted, no overflow
    tbl[6]  = '{64'h80000110, 32'h13, 5'd3, 64'h110, 1'b1,
                1'b1, 64'h80000104, 3'd4, 1'b0, 64'd2};
    // Full without pop: dropped, overflow sticks
    tbl[7]  = '{64'h80000114, 32'h13, 5'd3, 64'h114, 1'b0,
                1'b1, 64'h80000104, 3'd4, 1'b1, 64'd2};
    tbl[8]  = '{64'h80000118, 32'h13, 5'd3, 64'h118, 1'b0,
                1'b1, 64'h80000104, 3'd4, 1'b1, 64'd2};
    tbl[9]  = '{PC_START, 32'h0, 5'd3, 64'd0, 1'b1, 1'b1, 64'h80000108, 3'd3, 1'b1, 64'd3};
    tbl[10] = '{PC_START, 32'h0, 5'd3, 64'd0, 1'b1, 1'b1, 64'h8000010C, 3'd2, 1'b1, 64'd4};
    tbl[11] = '{PC_START, 32'h0, 5'd3, 64'd0, 1'b1, 1'b1, 64'h80000110, 3'd1, 1'b1, 64'd5};
    tbl[12] = '{64'h0, 32'h0, 5'd3, 64'd0, 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 64'd6};

    // Reset state
    do_reset();
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cycle", cycle_cnt, 0);

    // Bubbles are never queued; cycle counter still runs
    for (int i = 0; i < 10; i++) bubble(1'b1);
    chk("bubble_cycle", cycle_cnt, 64'd10);
    chk("bubble_count", count, 0);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].pc, tbl[i].inst, 8'hFF, tbl[i].wnum, tbl[i].wdata, 64'h0, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eovf);
      chk($sformatf("tbl%0d_instr", i), instr_cnt, tbl[i].eins);
    end

    // Trap: three commits, the trap, held off for 5 cycles, then drained
    do_reset();
    commit(64'h80000300, 32'h13, 64'h0, 1'b0);
    commit(64'h80000304, 32'h13, 64'h0, 1'b0);
    commit(64'h80000308, 32'h13, 64'h0, 1'b0);
    commit(64'h8000030C, 32'h0000006b, 64'h2A, 1'b0);
    for (int i = 0; i < 5; i++) commit(64'h80000400 + 64'(4 * i), 32'h13, 64'h0, 1'b0);
    chk("drain_ignores_input", count, 4);
    chk("drain_no_trap", trap, 0);
    for (int i = 0; i < 4; i++) begin
      commit(64'h80000500, 32'h13, 64'h0, 1'b1);
      chk($sformatf("drain_pop%0d_trap", i), trap, i == 3);
    end
    chk("halt_code", trap_code, 8'h2A);
    chk("halt_pc", trap_pc, 64'h8000030C);
    chk("halt_instr", instr_cnt, 64'd4);
    chk("halt_cycle", cycle_cnt, 64'd13);
    for (int i = 0; i < 3; i++) commit(64'h80000600, 32'h0000006b, 64'h55, 1'b1);
    chk("halt_cycle_frozen", cycle_cnt, 64'd13);
    chk("halt_code_kept", trap_code, 8'h2A);
    chk("halt_no_valid", out_valid, 0);

    // Reset while draining with two entries queued
    do_reset();
    commit(64'h80000700, 32'h13, 64'h0, 1'b0);
    commit(64'h80000704, 32'h0000006b, 64'h11, 1'b0);
    chk("pre_rst_count", count, 2);
    do_reset();
    chk("rst_drain_count", count, 0);
    chk("rst_drain_trap", trap, 0);
    chk("rst_drain_cycle", cycle_cnt, 0);
    chk("rst_drain_code", trap_code, 0);
    commit(64'h80000800, 32'h13, 64'h0, 1'b0);
    chk("rst_drain_accept", count, 1);
    chk("rst_drain_head", out_pc, 64'h80000800);

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 15))
        0, 1:    rpc = PC_START;
        2:       rpc = 64'h0;
        default: rpc = {$urandom(), $urandom()};
      endcase
      rinst = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      if ($urandom_range(0, 39) == 0) rinst[6:0] = 7'h6b;
      else if (rinst[6:0] == 7'h6b) rinst[6:0] = 7'h13;
      step(($urandom_range(0, 399) == 0),
           rpc, rinst,
           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom()),
           ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom()),
           {$urandom(), $urandom()},
           {$urandom(), $urandom()},
           ($urandom_range(0, 9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Sits between the pipeline's writeback debug outputs and the difftest commit/trap reporting logic in the simulation top. Each cycle it qualifies a retiring instruction and queues it in a small FIFO. It drains the FIFO to the difftest side with a valid/ready handshake. It also owns trap detection, trap-code capture, and the cycle and instruction counters, so trap is reported only after every earlier commit has been consumed.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
PC_START, 64'h0000_0000_8000_0000, reset PC; a commit carrying this PC with inst==0 is a bubble.
TRAP_OPCODE, 7'h6b, inst[6:0] value marking the simulation trap instruction.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_pc  in  64  writeback PC
wb_inst  in  32  writeback instruction
wb_rf_we  in  8  writeback regfile write enable (any bit set = write)
wb_rf_wnum  in  5  writeback destination register
wb_rf_wdata  in  64  writeback data
a0_value  in  64  current architectural x10, sampled for the trap code
out_ready  in  1  consumer accepts head entry
out_valid  out  1  head entry present
out_pc  out  64  head PC
out_inst  out  32  head instruction
out_rfwen  out  1  head writes a nonzero register
out_wdest  out  8  {3'b0, wnum}
out_wdata  out  64  head write data
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a valid commit was dropped
trap  out  1  trap reported; all prior commits drained
trap_code  out  8  a0_value[7:0] captured at the trap commit
trap_pc  out  64  PC of the trap instruction
cycle_cnt  out  64  cycles elapsed while not halted
instr_cnt  out  64  entries popped

Behaviour:
- Reset, synchronous: FIFO empty, state RUN, and all outputs 0 (out_valid, count, overflow, trap, trap_code, trap_pc, cycle_cnt, instr_cnt, out_*). A reset asserted mid-drain or mid-halt discards all entries and returns to RUN the next cycle.
- Commit qualification (combinational): in_valid = ((wb_pc != PC_START) && (wb_pc != 0)) || (wb_inst != 0).
- Entry fields: rfwen = (|wb_rf_we) && (wb_rf_wnum != 0); wdest = {3'b0, wb_rf_wnum}.
- Push: when state==RUN and in_valid. The entry is written at the clock edge and is visible on out_* no earlier than the next cycle (1-cycle latency).
- Pop: when out_valid && out_ready. The head advances at the edge and instr_cnt increments by 1.
- Full: a push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle. Otherwise the commit is dropped and overflow is set; overflow stays set until reset.
- Empty: out_valid=0 and all out_* fields read 0. A push into an empty FIFO does not bypass to the output in the same cycle.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- State machine:
  RUN: a pushed commit with wb_inst[6:0]==TRAP_OPCODE is enqueued normally. On that edge trap_code<=a0_value[7:0], trap_pc<=wb_pc, and the state moves to DRAIN. If that trap commit is dropped because the FIFO is full, trap_code and trap_pc are still captured, overflow is set, and the state still moves to DRAIN.
  DRAIN: all inputs are ignored (no pushes, no counter effect from wb_*). Pops continue. Move to HALTED on the cycle the FIFO is empty, including at the edge where the last pop empties it.
  HALTED: trap=1, held until reset. No pushes. out_valid=0.
- cycle_cnt increments by 1 every cycle in RUN and DRAIN, and freezes in HALTED. It wraps modulo 2^64.
- Only one trap is recorded per reset. trap_code and trap_pc are not overwritten after the first capture.

Test Plan:
- Reset, then one commit (pc=0x80000004, inst=0x00100093, we=0xFF, wnum=1, wdata=1) with out_ready=1 -> next cycle out_valid=1, out_rfwen=1, out_wdest=1, out_wdata=1. After the pop, instr_cnt=1.
- Bubble: pc=PC_START, inst=0 for 10 cycles -> count stays 0, out_valid=0, cycle_cnt=10.
- Backpressure: out_ready=0 with 6 consecutive valid commits (DEPTH=4) -> count=4, overflow=1. Then out_ready=1 -> exactly the first 4 PCs pop in order.
- Full plus simultaneous pop: count=4, out_ready=1, new commit arrives -> accepted, count stays 4, overflow remains 0.
- Trap: 3 queued commits, then inst=0x0000006b with a0_value=0x2A, out_ready=0 for 5 cycles, then 1 -> trap=0 until the 4th pop. trap=1 in the cycle after the FIFO empties, trap_code=0x2A, instr_cnt=4, and cycle_cnt freezes.
- Reset during DRAIN with 2 entries queued -> next cycle count=0, trap=0, counters 0, state RUN, and the next valid commit is accepted.
